window_gen_3x3: RTL

Streaming 3x3 window generator feeding the Sobel core. Accepts 4-bit grayscale pixels in raster order over a valid/ready handshake, buffers the two previous image rows, and emits one packed 36-bit neighbourhood (pixels A..I) per interior pixel position. It sits directly upstream of the Sobel core; its `data_o` / `valid_o` / `ready_i` connect to the core's `data_i` / `valid_i` / `ready_o`.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/row_delay.sv | 26 ++
 rtl/window_gen_3x3.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: pixel/window widths and the packed
// 3x3 neighbourhood, A in the MSBs down to I in the LSBs.
package sobel_pkg;

    localparam int PIXEL_W = 4;
    localparam int WIN_W   = 36;

    typedef struct packed {
        logic [PIXEL_W-1:0] a;
        logic [PIXEL_W-1:0] b;
        logic [PIXEL_W-1:0] c;
        logic [PIXEL_W-1:0] d;
        logic [PIXEL_W-1:0] e;
        logic [PIXEL_W-1:0] f;
        logic [PIXEL_W-1:0] g;
        logic [PIXEL_W-1:0] h;
        logic [PIXEL_W-1:0] i;
    } window_t;

    typedef enum logic {
        PH_FILL,
        PH_RUN
    } phase_t;

endpackage

// File: rtl/row_delay.sv
// One image row of pixel delay: combinational read of the old entry at
// idx_i, overwritten with data_i on the same enabled edge.
module row_delay
    import sobel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [AW-1:0]      idx_i,
    input  logic [PIXEL_W-1:0] data_i,
    output logic [PIXEL_W-1:0] data_o
);

    logic [PIXEL_W-1:0] mem_q [DEPTH];

    assign data_o = mem_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two row delays plus a 3x3 shift window,
// emitting one registered neighbourhood per interior pixel position.
module window_gen_3x3
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [PIXEL_W-1:0] data_i,
    input  logic               sof_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [WIN_W-1:0]   data_o,
    output logic               last_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    window_t       win_q, win_d, out_q, out_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          accept, emit;
    phase_t        phase;
    logic [PIXEL_W-1:0] lb_in  [2];
    logic [PIXEL_W-1:0] lb_out [2];

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    // A start-of-frame pixel is position (0,0) regardless of the counters.
    assign col_cur = sof_i ? '0 : col_q;
    assign row_cur = sof_i ? '0 : row_q;
    assign phase   = (row_cur >= RW'(2)) ? PH_RUN : PH_FILL;
    assign emit    = accept && (phase == PH_RUN) && (col_cur >= CW'(2));

    // lb_out[0] is the row above (mid), lb_out[1] two rows above (top).
    assign lb_in[0] = data_i;
    assign lb_in[1] = lb_out[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_row
            row_delay #(
                .DEPTH (WIDTH)
            ) u_row_delay (
                .clk_i  (clk_i),
                .en_i   (accept),
                .idx_i  (col_cur),
                .data_i (lb_in[gi]),
                .data_o (lb_out[gi])
            );
        end
    endgenerate

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            win_d.a = win_q.b;
            win_d.b = win_q.c;
            win_d.c = lb_out[1];
            win_d.d = win_q.e;
            win_d.e = win_q.f;
            win_d.f = lb_out[0];
            win_d.g = win_q.h;
            win_d.h = win_q.i;
            win_d.i = data_i;

            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end

        if (emit) begin
            out_d   = win_d;
            valid_d = 1'b1;
            last_d  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
    end

    // Window contents are only ever observed after being refilled in-frame.
    always_ff @(posedge clk_i) begin
        win_q <= win_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            col_q   <= '0;
            row_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = out_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule
